// File: rtl/regfile_wb_pkg.sv
// Shared widths and constants for the MIPS general-purpose register file.
// Consumers: regfile_wb (top) and regfile_fwd_mux (read-port forwarding mux).
package regfile_wb_pkg;

  // Default register and address widths (RegBus / RegAddrBus).
  localparam int unsigned RegBusW  = 32;
  localparam int unsigned RegAddrW = 5;

  // Architectural register count.
  localparam int unsigned RegNum   = 32;

  // Width of the committed-write counter seen by the difftest bench.
  localparam int unsigned WcountW  = 32;

  // $0 address and the all-zero word.
  localparam logic [RegAddrW-1:0] ZeroRegAddr = '0;
  localparam logic [RegBusW-1:0]  ZeroWord    = '0;

endpackage : regfile_wb_pkg

// File: rtl/regfile_fwd_mux.sv
// Read-port resolver for the register file: picks zero, same-cycle write-back
// data, or the stored array word, in that priority order.
// Ports:
//   rst      - synchronous reset level; forces the read result to zero
//   raddr    - read address (rs or rt)
//   arr_word - stored array word at raddr
//   we       - write-back enable
//   waddr    - write-back destination address
//   wdata    - write-back data
//   rdata    - resolved read data (combinational)
module regfile_fwd_mux
  import regfile_wb_pkg::*;
#(
  parameter int unsigned DATA_W = RegBusW,
  parameter int unsigned ADDR_W = RegAddrW,
  parameter bit          BYPASS = 1'b1
) (
  input  logic              rst,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] arr_word,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic w_is_zero;
  logic w_hit;

  assign w_is_zero = (raddr == ADDR_W'(ZeroRegAddr));
  // A write to $0 can never hit because the zero check is taken first.
  assign w_hit     = BYPASS && we && (waddr == raddr);

  // Priority: reset, $0, bypass, stored value.
  always_comb begin
    rdata = DATA_W'(ZeroWord);
    if (rst) begin
      rdata = DATA_W'(ZeroWord);
    end else if (w_is_zero) begin
      rdata = DATA_W'(ZeroWord);
    end else if (w_hit) begin
      rdata = wdata;
    end else begin
      rdata = arr_word;
    end
  end

endmodule : regfile_fwd_mux

// File: rtl/regfile_wb.sv
// General-purpose register file for the 5-stage MIPS pipeline; terminates the
// write-back interface and serves two combinational read ports to ID.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   we, waddr, wdata  - write-back port (RegWrite / regdst / wdata)
//   raddr1, raddr2    - read addresses (rs / rt)
//   rdata1, rdata2    - read data, combinational, with optional WB bypass
//   dbg_valid         - one committed write happened on the previous edge
//   dbg_waddr/wdata   - address/data of the most recent committed write
//   dbg_wcount        - committed writes since reset, wraps modulo 2^32
module regfile_wb
  import regfile_wb_pkg::*;
#(
  parameter int unsigned DATA_W = RegBusW,
  parameter int unsigned ADDR_W = RegAddrW,
  parameter bit          BYPASS = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [DATA_W-1:0]  wdata,
  input  logic [ADDR_W-1:0]  raddr1,
  input  logic [ADDR_W-1:0]  raddr2,
  output logic [DATA_W-1:0]  rdata1,
  output logic [DATA_W-1:0]  rdata2,
  output logic               dbg_valid,
  output logic [ADDR_W-1:0]  dbg_waddr,
  output logic [DATA_W-1:0]  dbg_wdata,
  output logic [WcountW-1:0] dbg_wcount
);

  // Array depth follows the address width; at the default width it is RegNum.
  localparam int unsigned NumRegs = (ADDR_W == RegAddrW) ? RegNum : (1 << ADDR_W);

  logic [DATA_W-1:0]  r_regs [NumRegs];
  logic               r_dbg_valid;
  logic [ADDR_W-1:0]  r_dbg_waddr;
  logic [DATA_W-1:0]  r_dbg_wdata;
  logic [WcountW-1:0] r_wcount;

  logic               w_commit;
  logic [DATA_W-1:0]  w_arr1;
  logic [DATA_W-1:0]  w_arr2;

  // Writes to $0 and writes coinciding with reset are discarded.
  assign w_commit = we && (waddr != ADDR_W'(ZeroRegAddr)) && !rst;

  assign w_arr1 = r_regs[raddr1];
  assign w_arr2 = r_regs[raddr2];

  // Register array; entry 0 is cleared on reset and never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NumRegs); i++) begin
        r_regs[i] <= DATA_W'(ZeroWord);
      end
    end else if (w_commit) begin
      r_regs[waddr] <= wdata;
    end
  end

  // Debug trace: valid pulses per commit, address/data hold between commits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dbg_valid <= 1'b0;
      r_dbg_waddr <= ADDR_W'(ZeroRegAddr);
      r_dbg_wdata <= DATA_W'(ZeroWord);
    end else begin
      r_dbg_valid <= w_commit;
      if (w_commit) begin
        r_dbg_waddr <= waddr;
        r_dbg_wdata <= wdata;
      end
    end
  end

  // Committed-write counter; natural wrap at the top of the range.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wcount <= '0;
    end else if (w_commit) begin
      r_wcount <= r_wcount + WcountW'(1);
    end
  end

  assign dbg_valid  = r_dbg_valid;
  assign dbg_waddr  = r_dbg_waddr;
  assign dbg_wdata  = r_dbg_wdata;
  assign dbg_wcount = r_wcount;

  regfile_fwd_mux #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_fwd_rs (
    .rst      (rst),
    .raddr    (raddr1),
    .arr_word (w_arr1),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .rdata    (rdata1)
  );

  regfile_fwd_mux #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_fwd_rt (
    .rst      (rst),
    .raddr    (raddr2),
    .arr_word (w_arr2),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .rdata    (rdata2)
  );

endmodule : regfile_wb

// File: tb/tb_regfile_wb.sv
// Self-checking bench for regfile_wb: a bypassing and a non-bypassing instance
// share the same stimulus and are compared against an array-based model.
module tb_regfile_wb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [4:0]  raddr1 = '0;
  logic [4:0]  raddr2 = '0;

  logic [31:0] rdata1_b, rdata2_b, dbg_wdata_b, dbg_wcount_b;
  logic [31:0] rdata1_n, rdata2_n, dbg_wdata_n, dbg_wcount_n;
  logic [4:0]  dbg_waddr_b, dbg_waddr_n;
  logic        dbg_valid_b, dbg_valid_n;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state.
  logic [31:0] m_regs [32];
  logic        m_valid;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic [31:0] m_wcount;

  always #5 clk = ~clk;

  regfile_wb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .raddr1     (raddr1),
    .raddr2     (raddr2),
    .rdata1     (rdata1_b),
    .rdata2     (rdata2_b),
    .dbg_valid  (dbg_valid_b),
    .dbg_waddr  (dbg_waddr_b),
    .dbg_wdata  (dbg_wdata_b),
    .dbg_wcount (dbg_wcount_b)
  );

  regfile_wb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) dut_nb (
    .clk        (clk),
    .rst        (rst),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .raddr1     (raddr1),
    .raddr2     (raddr2),
    .rdata1     (rdata1_n),
    .rdata2     (rdata2_n),
    .dbg_valid  (dbg_valid_n),
    .dbg_waddr  (dbg_waddr_n),
    .dbg_wdata  (dbg_wdata_n),
    .dbg_wcount (dbg_wcount_n)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected read value from the architectural rules.
  function automatic logic [31:0] exp_read(input logic [4:0] ra, input bit bypass);
    if (rst) return 32'h0;
    if (ra == 5'd0) return 32'h0;
    if (bypass && we && (waddr == ra)) return wdata;
    return m_regs[ra];
  endfunction

  // Apply one cycle of stimulus (called just after a falling edge): check the
  // combinational reads, advance the model on the rising edge, then check the
  // registered debug outputs after the following falling edge.
  task automatic cycle(input logic r, input logic w, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] ra1, input logic [4:0] ra2);
    bit commit;
    rst = r; we = w; waddr = wa; wdata = wd; raddr1 = ra1; raddr2 = ra2;
    #1;
    check("rdata1_byp",   rdata1_b, exp_read(ra1, 1'b1));
    check("rdata2_byp",   rdata2_b, exp_read(ra2, 1'b1));
    check("rdata1_nobyp", rdata1_n, exp_read(ra1, 1'b0));
    check("rdata2_nobyp", rdata2_n, exp_read(ra2, 1'b0));
    @(posedge clk);
    if (r) begin
      foreach (m_regs[i]) m_regs[i] = 32'h0;
      m_valid = 1'b0; m_waddr = 5'd0; m_wdata = 32'h0; m_wcount = 32'h0;
    end else begin
      commit = w && (wa != 5'd0);
      m_valid = commit;
      if (commit) begin
        m_regs[wa] = wd;
        m_waddr = wa;
        m_wdata = wd;
        m_wcount = m_wcount + 32'd1;
      end
    end
    @(negedge clk);
    check("dbg_valid_byp",    {31'd0, dbg_valid_b}, {31'd0, m_valid});
    check("dbg_waddr_byp",    {27'd0, dbg_waddr_b}, {27'd0, m_waddr});
    check("dbg_wdata_byp",    dbg_wdata_b,  m_wdata);
    check("dbg_wcount_byp",   dbg_wcount_b, m_wcount);
    check("dbg_valid_nobyp",  {31'd0, dbg_valid_n}, {31'd0, m_valid});
    check("dbg_waddr_nobyp",  {27'd0, dbg_waddr_n}, {27'd0, m_waddr});
    check("dbg_wdata_nobyp",  dbg_wdata_n,  m_wdata);
    check("dbg_wcount_nobyp", dbg_wcount_n, m_wcount);
  endtask

  initial begin
    logic [4:0] wa, ra1, ra2;
    foreach (m_regs[i]) m_regs[i] = 32'h0;
    m_valid = 1'b0; m_waddr = 5'd0; m_wdata = 32'h0; m_wcount = 32'h0;
    @(negedge clk);

    // Reset held for two cycles with a write pending; the write must be lost.
    cycle(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5);
    cycle(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
    cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    check("post_reset_rdata1", rdata1_b, 32'h0);

    // Write then read on the following cycle.
    cycle(1'b0, 1'b1, 5'd8, 32'h12345678, 5'd0, 5'd0);
    check("wr_dbg_valid",  {31'd0, dbg_valid_b}, 32'd1);
    check("wr_dbg_wcount", dbg_wcount_b, 32'd1);
    cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd8);
    check("wr_readback", rdata2_b, 32'h12345678);
    check("wr_dbg_drop", {31'd0, dbg_valid_b}, 32'd0);

    // Bypass: both ports on the register being written this cycle.
    cycle(1'b0, 1'b1, 5'd9, 32'h00000001, 5'd0, 5'd0);
    cycle(1'b0, 1'b1, 5'd9, 32'hAAAA5555, 5'd9, 5'd9);
    cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9);

    // $0 writes are dropped and never bypassed.
    cycle(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd9);

    // Back-to-back writes to the same register.
    cycle(1'b0, 1'b1, 5'd3, 32'h11111111, 5'd3, 5'd0);
    cycle(1'b0, 1'b1, 5'd3, 32'h22222222, 5'd3, 5'd3);
    cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3);

    // Reset in the cycle of the fifth write of a burst.
    for (int i = 1; i <= 4; i++)
      cycle(1'b0, 1'b1, 5'(i), 32'hC0DE0000 + 32'(i), 5'(i), 5'(i - 1));
    cycle(1'b1, 1'b1, 5'd5, 32'hC0DE0005, 5'd1, 5'd5);
    check("mid_reset_wcount", dbg_wcount_b, 32'd0);
    for (int i = 0; i < 32; i += 2)
      cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(i + 1));

    // Counter wrap: preload the counter, one idle edge latches it, one commit wraps.
    force dut.r_wcount = 32'hFFFFFFFF;
    force dut_nb.r_wcount = 32'hFFFFFFFF;
    m_wcount = 32'hFFFFFFFF;
    cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
    release dut.r_wcount;
    release dut_nb.r_wcount;
    cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
    cycle(1'b0, 1'b1, 5'd7, 32'h0BADF00D, 5'd7, 5'd0);
    check("wrap_wcount", dbg_wcount_b, 32'h0);
    check("wrap_valid",  {31'd0, dbg_valid_b}, 32'd1);

    // Random traffic, addresses biased low so bypass hits are frequent.
    for (int n = 0; n < 600; n++) begin
      wa  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      ra1 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      ra2 = ($urandom_range(0, 1) == 0) ? ra1 : 5'($urandom_range(0, 7));
      cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), wa, $urandom, ra1, ra2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_regfile_wb
